counter_trigger_sequencer: RTL

Controller for the counter-delayed trigger block. Averages the period lengths that block reports on `last_counter`, drives its `reference_counter`, and sequences its `trigger_arm` / `trigger_reset` pulses to produce a programmed number of held trigger events. It sits between the trigger block and the AXI register bank; `num_triggers`, `hold_cycles` and the period window are register-driven.

---
 rtl/counter_trigger_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/counter_trigger_sequencer.sv
// Averages trigger-block period reports and sequences arm/hold/reset cycles for N trigger events.
// Latency: last_counter change -> reference_counter 3 cycles; trigger seen -> trigger_reset after hold_cycles+2.
// Backpressure: none; waits on trigger_armed/trigger handshakes from the trigger block, abort preempts.
module counter_trigger_sequencer #(
    parameter int TRIGGER_COUNTER_WIDTH = 32,
    parameter int AVG_LOG2              = 3,
    parameter int HOLD_WIDTH            = 32
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic                             enable,
    input  logic                             start,
    input  logic                             abort,
    input  logic [TRIGGER_COUNTER_WIDTH-1:0] last_counter,
    input  logic                             trigger,
    input  logic                             trigger_armed,
    input  logic [TRIGGER_COUNTER_WIDTH-1:0] min_period,
    input  logic [TRIGGER_COUNTER_WIDTH-1:0] max_period,
    input  logic [15:0]                      num_triggers,
    input  logic [HOLD_WIDTH-1:0]            hold_cycles,
    output logic                             trigger_arm,
    output logic                             trigger_reset,
    output logic [TRIGGER_COUNTER_WIDTH-1:0] reference_counter,
    output logic                             reference_valid,
    output logic [15:0]                      trigger_count,
    output logic [7:0]                       period_rejects,
    output logic                             busy,
    output logic                             done,
    output logic [3:0]                       state
);
    localparam int W      = TRIGGER_COUNTER_WIDTH;
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = W + AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = AVG_LOG2 + 1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_REF   = 4'd1,
        ST_ARM        = 4'd2,
        ST_WAIT_ARMED = 4'd3,
        ST_ARMED      = 4'd4,
        ST_HOLD       = 4'd5,
        ST_RESET      = 4'd6,
        ST_CLEAR      = 4'd7,
        ST_DONE       = 4'd8
    } st_e;

    st_e                  cur_st, nxt_st;
    logic [W-1:0]         lc_q, lc_prev;
    logic [W-1:0]         win [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [SUM_W-1:0]     sum, sum_nxt;
    logic [FILL_W-1:0]    fill;
    logic [W-1:0]         avg;
    logic                 sample_vld, in_window, ref_load;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic                 abort_pend;
    logic                 cnt_clr, cnt_inc, hold_load, hold_dec, pend_set, pend_clr;

    // A new period is any nonzero change of the registered report; repeats are not re-averaged.
    assign sample_vld = (lc_q != lc_prev) && (lc_q != '0);
    assign in_window  = (lc_q >= min_period) && (lc_q <= max_period);
    assign sum_nxt    = sum + SUM_W'(lc_q) - SUM_W'(win[wr_ptr]);
    assign avg        = W'(sum >> AVG_LOG2);
    // Threshold may only move while the trigger block is not armed.
    assign ref_load   = (cur_st == ST_IDLE) || (cur_st == ST_WAIT_REF) ||
                        (cur_st == ST_CLEAR) || (cur_st == ST_DONE);
    assign state      = cur_st;

    // Period capture, ring-buffer averaging window and reject counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lc_q           <= '0;
            lc_prev        <= '0;
            wr_ptr         <= '0;
            sum            <= '0;
            fill           <= '0;
            period_rejects <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else if (!enable) begin
            lc_q           <= '0;
            lc_prev        <= '0;
            wr_ptr         <= '0;
            sum            <= '0;
            fill           <= '0;
            period_rejects <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else begin
            lc_q    <= last_counter;
            lc_prev <= lc_q;
            if (sample_vld) begin
                if (in_window) begin
                    win[wr_ptr] <= lc_q;
                    sum         <= sum_nxt;
                    wr_ptr      <= (AVG_LOG2 == 0) ? '0 : wr_ptr + PTR_W'(1);
                    if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
                end else if (period_rejects != 8'hFF) begin
                    period_rejects <= period_rejects + 8'd1;
                end
            end
        end
    end

    // Reference output: valid tracks window fill, value loads only in unfrozen states.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            reference_counter <= '0;
            reference_valid   <= 1'b0;
        end else if (!enable) begin
            reference_counter <= '0;
            reference_valid   <= 1'b0;
        end else begin
            reference_valid <= (fill == FILL_W'(DEPTH));
            if (ref_load) reference_counter <= avg;
        end
    end

    // Next-state and control decode; abort outranks start and trigger everywhere.
    always_comb begin
        nxt_st    = cur_st;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        case (cur_st)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    cnt_clr  = 1'b1;
                    pend_clr = 1'b1;
                    nxt_st   = ST_WAIT_REF;
                end
            end
            ST_WAIT_REF: begin
                if (abort)                nxt_st = ST_IDLE;
                else if (reference_valid) nxt_st = ST_ARM;
            end
            ST_ARM: begin
                pend_set = abort;
                nxt_st   = abort ? ST_RESET : ST_WAIT_ARMED;
            end
            ST_WAIT_ARMED: begin
                if (abort) begin
                    pend_set = 1'b1;
                    nxt_st   = ST_RESET;
                end else if (trigger_armed) begin
                    nxt_st = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    pend_set = 1'b1;
                    nxt_st   = ST_RESET;
                end else if (trigger) begin
                    cnt_inc   = 1'b1;
                    hold_load = 1'b1;
                    nxt_st    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    pend_set = 1'b1;
                    nxt_st   = ST_RESET;
                end else if (hold_cnt == '0) begin
                    nxt_st = ST_RESET;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_RESET: begin
                pend_set = abort;
                nxt_st   = ST_CLEAR;
            end
            ST_CLEAR: begin
                pend_set = abort;
                if (!trigger_armed && !trigger) begin
                    if (abort_pend || abort) begin
                        pend_clr = 1'b1;
                        nxt_st   = ST_IDLE;
                    end else if ((num_triggers != 16'd0) && (trigger_count >= num_triggers)) begin
                        nxt_st = ST_DONE;
                    end else begin
                        nxt_st = ST_ARM;
                    end
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    // State register plus registered pulses, status flags, event and hold counters.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cur_st        <= ST_IDLE;
            trigger_arm   <= 1'b0;
            trigger_reset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            trigger_count <= '0;
            hold_cnt      <= '0;
            abort_pend    <= 1'b0;
        end else if (!enable) begin
            cur_st        <= ST_IDLE;
            trigger_arm   <= 1'b0;
            trigger_reset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            trigger_count <= '0;
            hold_cnt      <= '0;
            abort_pend    <= 1'b0;
        end else begin
            cur_st        <= nxt_st;
            trigger_arm   <= (nxt_st == ST_ARM);
            trigger_reset <= (nxt_st == ST_RESET);
            busy          <= (nxt_st != ST_IDLE) && (nxt_st != ST_DONE);
            done          <= (nxt_st == ST_DONE);
            if (cnt_clr)                                 trigger_count <= '0;
            else if (cnt_inc && trigger_count != 16'hFFFF) trigger_count <= trigger_count + 16'd1;
            if (hold_load)     hold_cnt <= hold_cycles;
            else if (hold_dec) hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
            if (pend_clr)      abort_pend <= 1'b0;
            else if (pend_set) abort_pend <= 1'b1;
        end
    end
endmodule
